// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference datapath.
// Product/feature widths and the accumulator FSM state encoding.
package mnist_pkg;

    localparam int PROD_W   = 16;
    localparam int FEAT_W   = 8;
    localparam int FEAT_MAX = 255;

    typedef enum logic {
        IDLE,
        ACCUM
    } acc_state_t;

endpackage

// File: rtl/requant_relu_sat.sv
// Combinational bias-add, ReLU, arithmetic right-shift requantization and
// unsigned saturation of one neuron's dot-product sum.
module requant_relu_sat
    import mnist_pkg::*;
#(
    parameter int ACC_W = 26,
    parameter int SHIFT = 7
) (
    input  logic signed [ACC_W-1:0]  sum,
    input  logic signed [PROD_W-1:0] bias,
    output logic        [FEAT_W-1:0] feature
);

    // One guard bit so the bias add cannot wrap a large sum into the opposite sign.
    logic signed [ACC_W:0] t;
    logic        [ACC_W:0] r;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        t       = (ACC_W+1)'(sum) + (ACC_W+1)'(bias);
        r       = '0;
        feature = '0;
        if (!t[ACC_W]) begin
            r = t >>> SHIFT;
            if (r > (ACC_W+1)'(FEAT_MAX)) begin
                feature = FEAT_W'(FEAT_MAX);
            end else begin
                feature = r[FEAT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates signed products per neuron, then requantizes to one 8-bit feature.
// Optional bias input is enabled by defining MAC_ACCUMULATOR_BIAS_EN.
module mac_accumulator
    import mnist_pkg::*;
#(
    parameter int ACC_W       = 26,
    parameter int SHIFT       = 7,
    parameter int NUM_NEURONS = 10,
    parameter int IDX_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prod_valid,
    input  logic                     prod_last,
    input  logic signed [PROD_W-1:0] prod,
`ifdef MAC_ACCUMULATOR_BIAS_EN
    input  logic signed [PROD_W-1:0] bias,
`endif
    output logic        [FEAT_W-1:0] feature_out,
    output logic        [IDX_W-1:0]  neuron_idx,
    output logic                     out_valid,
    output logic                     layer_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    acc_state_t               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic signed [PROD_W-1:0] bias_q, bias_d;
    logic                     fv_q, fv_d;
    logic        [IDX_W-1:0]  idx_q, idx_d;
    logic        [FEAT_W-1:0] feature_q, feature_d;
    logic        [IDX_W-1:0]  nidx_q, nidx_d;
    logic                     ov_q, ov_d;
    logic                     ld_q, ld_d;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  base;
    logic signed [PROD_W-1:0] bias_in;
    logic        [FEAT_W-1:0] feat_c;

`ifdef MAC_ACCUMULATOR_BIAS_EN
    assign bias_in = bias;
`else
    assign bias_in = '0;
`endif

    requant_relu_sat #(
        .ACC_W(ACC_W),
        .SHIFT(SHIFT)
    ) u_requant (
        .sum    (sum_q),
        .bias   (bias_q),
        .feature(feat_c)
    );

    always_comb begin
        prod_ext  = ACC_W'(prod);
        // Starting from zero in IDLE keeps a new neuron clean of the previous sum.
        base      = (state_q == ACCUM) ? acc_q : '0;
        state_d   = state_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        bias_d    = bias_q;
        fv_d      = 1'b0;
        if (prod_valid) begin
            if (prod_last) begin
                sum_d   = base + prod_ext;
                bias_d  = bias_in;
                acc_d   = '0;
                state_d = IDLE;
                fv_d    = 1'b1;
            end else begin
                acc_d   = base + prod_ext;
                state_d = ACCUM;
            end
        end

        feature_d = feature_q;
        nidx_d    = nidx_q;
        idx_d     = idx_q;
        ov_d      = fv_q;
        ld_d      = 1'b0;
        if (fv_q) begin
            feature_d = feat_c;
            nidx_d    = idx_q;
            ld_d      = (idx_q == LAST_IDX);
            idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sum_q     <= '0;
            bias_q    <= '0;
            fv_q      <= 1'b0;
            idx_q     <= '0;
            feature_q <= '0;
            nidx_q    <= '0;
            ov_q      <= 1'b0;
            ld_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            bias_q    <= bias_d;
            fv_q      <= fv_d;
            idx_q     <= idx_d;
            feature_q <= feature_d;
            nidx_q    <= nidx_d;
            ov_q      <= ov_d;
            ld_q      <= ld_d;
        end
    end

    assign feature_out = feature_q;
    assign neuron_idx  = nidx_q;
    assign out_valid   = ov_q;
    assign layer_done  = ld_q;

endmodule
